// File: rtl/byte_issue_pkg.sv
// Shared types and constants for the byte issue queue.
package byte_issue_pkg;

    localparam int unsigned DATA_W_DEFAULT = 8;
    localparam int unsigned GAP_MAX        = 15;
    localparam int unsigned GAP_CNT_W      = $clog2(GAP_MAX + 1);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        GAP
    } state_t;

endpackage

// File: rtl/byte_issue_fifo_mem.sv
// DEPTH x DATA_W register FIFO with wrapping pointers and occupancy level.
module byte_issue_fifo_mem #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 8
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     pop,
    output logic [DATA_W-1:0]        rd_data,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;

    // Data array carries no reset; only valid entries are ever read out.
    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Power-of-two depth lets the pointers wrap by natural overflow.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

    assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/byte_issue_queue.sv
// Ready/valid byte buffer that issues single-cycle pulses spaced by at least GAP idle cycles.
module byte_issue_queue #(
    parameter int unsigned DATA_W = byte_issue_pkg::DATA_W_DEFAULT,
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned GAP    = 1
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic [DATA_W-1:0]        in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     issue_en,
    output logic [DATA_W-1:0]        out_data,
    output logic                     out_valid,
    output logic [$clog2(DEPTH):0]   level,
    output logic [15:0]              issued_count
);

    import byte_issue_pkg::*;

    state_t                 state;
    state_t                 state_next;
    logic [GAP_CNT_W-1:0]   gap_cnt;
    logic [GAP_CNT_W-1:0]   gap_next;
    logic [DATA_W-1:0]      head;
    logic                   push;
    logic                   pop;
    logic                   can_issue;

    // No full-bypass: a full queue refuses pushes even when popping.
    assign in_ready  = reset_n && (32'(level) < DEPTH);
    assign push      = in_valid && in_ready;
    assign can_issue = issue_en && (level != '0);

    byte_issue_fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clock   (clock),
        .reset_n (reset_n),
        .push    (push),
        .wr_data (in_data),
        .pop     (pop),
        .rd_data (head),
        .level   (level)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            gap_cnt      <= '0;
            out_valid    <= 1'b0;
            out_data     <= '0;
            issued_count <= '0;
        end else begin
            state     <= state_next;
            gap_cnt   <= gap_next;
            out_valid <= pop;
            if (pop) begin
                out_data     <= head;
                issued_count <= issued_count + 16'd1;
            end
        end
    end

    // The last gap cycle re-runs the idle issue test so GAP=n yields exactly n idle cycles.
    always_comb begin
        state_next = state;
        gap_next   = gap_cnt;
        pop        = 1'b0;
        case (state)
            IDLE: begin
                if (can_issue) begin
                    pop        = 1'b1;
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                if (GAP == 0) begin
                    if (can_issue) begin
                        pop = 1'b1;
                    end else begin
                        state_next = IDLE;
                    end
                end else begin
                    gap_next   = GAP_CNT_W'(GAP - 1);
                    state_next = byte_issue_pkg::GAP;
                end
            end
            byte_issue_pkg::GAP: begin
                if (gap_cnt != '0) begin
                    gap_next = gap_cnt - GAP_CNT_W'(1);
                end else if (can_issue) begin
                    pop        = 1'b1;
                    state_next = ISSUE;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_byte_issue_queue.sv
// Directed-vector bench for byte_issue_queue at GAP=1, GAP=0 and GAP=3.
module tb_byte_issue_queue;

    logic        clock;
    logic        reset_n;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        issue_en;

    logic        rdy1, ov1, rdy0, ov0, rdy3, ov3;
    logic [7:0]  od1, od0, od3;
    logic [3:0]  lv1, lv0, lv3;
    logic [15:0] ic1, ic0, ic3;

    logic [7:0]  stage_q;

    int vec_cnt     = 0;
    int miscompares = 0;

    byte_issue_queue #(.DATA_W(8), .DEPTH(8), .GAP(1)) u_g1 (
        .clock(clock), .reset_n(reset_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(rdy1), .issue_en(issue_en), .out_data(od1), .out_valid(ov1),
        .level(lv1), .issued_count(ic1)
    );

    byte_issue_queue #(.DATA_W(8), .DEPTH(8), .GAP(0)) u_g0 (
        .clock(clock), .reset_n(reset_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(rdy0), .issue_en(issue_en), .out_data(od0), .out_valid(ov0),
        .level(lv0), .issued_count(ic0)
    );

    byte_issue_queue #(.DATA_W(8), .DEPTH(8), .GAP(3)) u_g3 (
        .clock(clock), .reset_n(reset_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(rdy3), .issue_en(issue_en), .out_data(od3), .out_valid(ov3),
        .level(lv3), .issued_count(ic3)
    );

    // Inverting register stage fed by the GAP=1 queue.
    always @(posedge clock) begin
        if (ov1) stage_q <= ~od1;
    end

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset_n  = 1'b0;
        in_valid = 1'b0;
        issue_en = 1'b0;
        in_data  = 8'h00;
        repeat (3) tick();
        reset_n = 1'b1;
        tick();
    endtask

    initial begin
        int  k;
        int  exp_n;
        int  pulses;
        logic acc;
        logic exp_ov;

        // 1: reset then idle
        reset_n  = 1'b0;
        in_valid = 1'b0;
        issue_en = 1'b0;
        in_data  = 8'h00;
        #1;
        check("rst_ready_low", 32'(rdy1), 32'(0));
        repeat (3) tick();
        check("rst_ready_low_held", 32'(rdy1), 32'(0));
        reset_n = 1'b1;
        tick();
        check("idle_ready", 32'(rdy1), 32'(1));
        check("idle_level", 32'(lv1), 32'(0));
        check("idle_valid", 32'(ov1), 32'(0));
        check("idle_data", 32'(od1), 32'(8'h00));
        check("idle_count", 32'(ic1), 32'(0));

        // 2: GAP=1, two bytes with one idle cycle between pulses
        in_data = 8'h12; in_valid = 1'b1; issue_en = 1'b1;
        tick();
        check("g1_lvl_e1", 32'(lv1), 32'(1));
        check("g1_ov_e1", 32'(ov1), 32'(0));
        in_data = 8'h55;
        tick();
        check("g1_ov_p1", 32'(ov1), 32'(1));
        check("g1_od_p1", 32'(od1), 32'(8'h12));
        check("g1_lvl_p1", 32'(lv1), 32'(1));
        in_valid = 1'b0;
        tick();
        check("g1_ov_gap", 32'(ov1), 32'(0));
        check("g1_stage_1", 32'(stage_q), 32'(8'hED));
        tick();
        check("g1_ov_p2", 32'(ov1), 32'(1));
        check("g1_od_p2", 32'(od1), 32'(8'h55));
        tick();
        check("g1_ov_end", 32'(ov1), 32'(0));
        check("g1_od_hold", 32'(od1), 32'(8'h55));
        check("g1_stage_2", 32'(stage_q), 32'(8'hAA));
        check("g1_count", 32'(ic1), 32'(2));

        // 3: fill to full with issuing disabled, then drain in order
        do_reset();
        k = 0;
        in_valid = 1'b1;
        for (int c = 0; c < 12; c++) begin
            in_data = 8'(k);
            acc = rdy1;
            tick();
            if (acc) k++;
        end
        check("fill_pushes", 32'(k), 32'(8));
        check("fill_level", 32'(lv1), 32'(8));
        check("fill_ready", 32'(rdy1), 32'(0));
        check("fill_no_pulse", 32'(ov1), 32'(0));
        issue_en = 1'b1;
        exp_n = 0;
        for (int c = 0; c < 40; c++) begin
            in_data  = 8'(k);
            in_valid = (k < 10);
            acc = in_valid && rdy1;
            tick();
            if (acc) k++;
            if (ov1) begin
                check("drain_order", 32'(od1), 32'(exp_n));
                exp_n++;
            end
        end
        in_valid = 1'b0;
        check("drain_pushed", 32'(k), 32'(10));
        check("drain_issued", 32'(exp_n), 32'(10));
        check("drain_level", 32'(lv1), 32'(0));
        check("drain_count", 32'(ic1), 32'(10));

        // 4: GAP=0 back-to-back stream
        do_reset();
        issue_en = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            in_valid = (c <= 4);
            in_data  = 8'(32'hA0 + c - 1);
            tick();
            exp_ov = (c >= 2 && c <= 5);
            check("g0_valid", 32'(ov0), 32'(exp_ov));
            if (exp_ov) check("g0_data", 32'(od0), 32'hA0 + 32'(c) - 32'd2);
            check("g0_level", 32'(lv0), (c <= 4) ? 32'd1 : 32'd0);
        end
        check("g0_count", 32'(ic0), 32'(4));

        // 5: GAP=3, issue_en dropped during the gap
        do_reset();
        for (int c = 1; c <= 14; c++) begin
            in_valid = (c <= 3);
            in_data  = 8'(32'hB0 + c - 1);
            issue_en = (c <= 2) || (c >= 9);
            tick();
            exp_ov = (c == 2) || (c == 9) || (c == 13);
            check("g3_valid", 32'(ov3), 32'(exp_ov));
            if (c == 2)  check("g3_data_b0", 32'(od3), 32'(8'hB0));
            if (c == 9)  check("g3_data_b1", 32'(od3), 32'(8'hB1));
            if (c == 13) check("g3_data_b2", 32'(od3), 32'(8'hB2));
        end
        check("g3_count", 32'(ic3), 32'(3));

        // 6: asynchronous reset while issuing with level=3
        do_reset();
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_data = 8'(32'hC0 + i);
            tick();
        end
        in_valid = 1'b0;
        check("mid_fill_level", 32'(lv1), 32'(4));
        issue_en = 1'b1;
        tick();
        check("mid_issue_valid", 32'(ov1), 32'(1));
        check("mid_issue_level", 32'(lv1), 32'(3));
        #2;
        reset_n = 1'b0;
        #1;
        check("async_valid", 32'(ov1), 32'(0));
        check("async_level", 32'(lv1), 32'(0));
        check("async_count", 32'(ic1), 32'(0));
        check("async_data", 32'(od1), 32'(0));
        check("async_ready", 32'(rdy1), 32'(0));
        tick();
        tick();
        reset_n = 1'b1;
        pulses = 0;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (ov1) pulses++;
        end
        check("no_stale_pulse", 32'(pulses), 32'(0));
        check("no_stale_level", 32'(lv1), 32'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscompares);
        $finish;
    end

endmodule
